// File: rtl/mem_issue_queue.sv
// Collapsing load/store issue queue: tag wakeup, in-order stores, mispredict flush; define MEMIQ_WAKEUP_BYPASS_EN for same-cycle wakeup select.
// Ready-to-output latency 1 cycle (2 after a wakeup without bypass); dp_ready low when full, iq_stall freezes the issue register.
module mem_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dp_valid,
  input  logic        dp_is_st,
  input  logic [2:0]  dp_rob_idx,
  input  logic [6:0]  dp_rd,
  input  logic [1:0]  dp_ld_idx,
  input  logic [1:0]  dp_st_idx,
  input  logic [31:0] dp_imm,
  input  logic [6:0]  dp_rs1_tag,
  input  logic        dp_rs1_rdy,
  input  logic [31:0] dp_rs1_data,
  input  logic [6:0]  dp_rs2_tag,
  input  logic        dp_rs2_rdy,
  input  logic [31:0] dp_rs2_data,
  output logic        dp_ready,
  input  logic        wb_valid,
  input  logic [6:0]  wb_tag,
  input  logic [31:0] wb_data,
  output logic        ld_i_valid,
  output logic        st_i_valid,
  output logic        RR_valid,
  output logic [2:0]  lsu_i_rob_idx,
  output logic [31:0] lsu_i_rs1_data,
  output logic [31:0] lsu_i_rs2_data,
  output logic [31:0] lsu_i_imm,
  output logic [1:0]  EX_ld_idx,
  output logic [1:0]  EX_st_idx,
  input  logic        iq_stall,
  input  logic        mispredict,
  input  logic [7:0]  flush_mask
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [6:0]  tag;
    logic        rdy;
    logic [31:0] data;
  } opnd_t;

  typedef struct packed {
    logic        valid;
    logic        is_st;
    logic [2:0]  rob_idx;
    logic [6:0]  rd;
    logic [1:0]  ld_idx;
    logic [1:0]  st_idx;
    logic [31:0] imm;
    opnd_t       rs1;
    opnd_t       rs2;
  } entry_t;

  typedef struct packed {
    logic        valid;
    logic        is_st;
    logic [2:0]  rob_idx;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [1:0]  ld_idx;
    logic [1:0]  st_idx;
  } issue_t;

  entry_t [DEPTH-1:0] q_q, q_d, woke;
  logic [CW-1:0]      count_q, count_d;
  issue_t             issue_q, issue_d;
  entry_t             dp_entry;
  logic [DEPTH-1:0]   elig, keep;
  logic               sel_vld, dp_fire, older_st;
  logic [IW-1:0]      sel_idx;
  int                 n;

  // Tag 0 means "no producer" and must never be woken.
  function automatic opnd_t wake(input opnd_t o, input logic v, input logic [6:0] t,
                                 input logic [31:0] d);
    opnd_t r;
    r = o;
    if (v && !o.rdy && (o.tag != 7'd0) && (o.tag == t)) begin
      r.rdy  = 1'b1;
      r.data = d;
    end
    return r;
  endfunction

  function automatic logic ops_rdy(input entry_t e);
    return e.rs1.rdy && (!e.is_st || e.rs2.rdy);
  endfunction

  assign dp_ready = rst && (count_q < CW'(DEPTH));
  assign dp_fire  = dp_valid && dp_ready && !mispredict;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i]     = q_q[i];
      woke[i].rs1 = wake(q_q[i].rs1, wb_valid, wb_tag, wb_data);
      woke[i].rs2 = wake(q_q[i].rs2, wb_valid, wb_tag, wb_data);
    end
  end

  always_comb begin
    dp_entry         = '0;
    dp_entry.valid   = 1'b1;
    dp_entry.is_st   = dp_is_st;
    dp_entry.rob_idx = dp_rob_idx;
    dp_entry.rd      = dp_rd;
    dp_entry.ld_idx  = dp_ld_idx;
    dp_entry.st_idx  = dp_st_idx;
    dp_entry.imm     = dp_imm;
    dp_entry.rs1     = wake('{tag: dp_rs1_tag, rdy: dp_rs1_rdy, data: dp_rs1_data},
                            wb_valid, wb_tag, wb_data);
    // A load never reads rs2, so it is born ready.
    dp_entry.rs2     = wake('{tag: dp_rs2_tag, rdy: dp_rs2_rdy || !dp_is_st, data: dp_rs2_data},
                            wb_valid, wb_tag, wb_data);
  end

  always_comb begin
    elig     = '0;
    older_st = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef MEMIQ_WAKEUP_BYPASS_EN
      elig[i] = woke[i].valid && ops_rdy(woke[i]) && !(woke[i].is_st && older_st);
`else
      elig[i] = q_q[i].valid && ops_rdy(q_q[i]) && !(q_q[i].is_st && older_st);
`endif
      older_st = older_st || (q_q[i].valid && q_q[i].is_st);
    end
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i] && !iq_stall && !mispredict) begin
        sel_vld = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  // Survivors slide down in age order; the dispatch lands just above them.
  always_comb begin
    q_d  = '0;
    keep = '0;
    n    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = woke[i].valid && !(sel_vld && (sel_idx == IW'(i)))
                && !(mispredict && flush_mask[woke[i].rob_idx]);
      if (keep[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == n) q_d[j] = woke[i];
        end
        n = n + 1;
      end
    end
    if (dp_fire) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j == n) q_d[j] = dp_entry;
      end
    end
    count_d = CW'(n) + CW'(dp_fire);
  end

  always_comb begin
    issue_d = issue_q;
    if (mispredict) begin
      if (flush_mask[issue_q.rob_idx] || !iq_stall) issue_d = '0;
    end else if (!iq_stall) begin
      issue_d = '0;
      if (sel_vld) begin
        issue_d.valid    = 1'b1;
        issue_d.is_st    = woke[sel_idx].is_st;
        issue_d.rob_idx  = woke[sel_idx].rob_idx;
        issue_d.rs1_data = woke[sel_idx].rs1.data;
        issue_d.rs2_data = woke[sel_idx].rs2.data;
        issue_d.imm      = woke[sel_idx].imm;
        issue_d.ld_idx   = woke[sel_idx].ld_idx;
        issue_d.st_idx   = woke[sel_idx].st_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q     <= '0;
      count_q <= '0;
      issue_q <= '0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      issue_q <= issue_d;
    end
  end

  assign ld_i_valid     = issue_q.valid && !issue_q.is_st;
  assign st_i_valid     = issue_q.valid && issue_q.is_st;
  assign RR_valid       = issue_q.valid;
  assign lsu_i_rob_idx  = issue_q.rob_idx;
  assign lsu_i_rs1_data = issue_q.rs1_data;
  assign lsu_i_rs2_data = issue_q.rs2_data;
  assign lsu_i_imm      = issue_q.imm;
  assign EX_ld_idx      = issue_q.ld_idx;
  assign EX_st_idx      = issue_q.st_idx;
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: reset, issue order, store ordering, full queue, flush, stall, tag 0.
module tb_mem_issue_queue;
`ifdef MEMIQ_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst;
  logic        dp_valid, dp_is_st;
  logic [2:0]  dp_rob_idx;
  logic [6:0]  dp_rd;
  logic [1:0]  dp_ld_idx, dp_st_idx;
  logic [31:0] dp_imm;
  logic [6:0]  dp_rs1_tag, dp_rs2_tag;
  logic        dp_rs1_rdy, dp_rs2_rdy;
  logic [31:0] dp_rs1_data, dp_rs2_data;
  logic        dp_ready;
  logic        wb_valid;
  logic [6:0]  wb_tag;
  logic [31:0] wb_data;
  logic        ld_i_valid, st_i_valid, RR_valid;
  logic [2:0]  lsu_i_rob_idx;
  logic [31:0] lsu_i_rs1_data, lsu_i_rs2_data, lsu_i_imm;
  logic [1:0]  EX_ld_idx, EX_st_idx;
  logic        iq_stall, mispredict;
  logic [7:0]  flush_mask;

  int checks = 0;
  int errors = 0;

  mem_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dp_valid(dp_valid), .dp_is_st(dp_is_st), .dp_rob_idx(dp_rob_idx), .dp_rd(dp_rd),
    .dp_ld_idx(dp_ld_idx), .dp_st_idx(dp_st_idx), .dp_imm(dp_imm),
    .dp_rs1_tag(dp_rs1_tag), .dp_rs1_rdy(dp_rs1_rdy), .dp_rs1_data(dp_rs1_data),
    .dp_rs2_tag(dp_rs2_tag), .dp_rs2_rdy(dp_rs2_rdy), .dp_rs2_data(dp_rs2_data),
    .dp_ready(dp_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .ld_i_valid(ld_i_valid), .st_i_valid(st_i_valid), .RR_valid(RR_valid),
    .lsu_i_rob_idx(lsu_i_rob_idx), .lsu_i_rs1_data(lsu_i_rs1_data),
    .lsu_i_rs2_data(lsu_i_rs2_data), .lsu_i_imm(lsu_i_imm),
    .EX_ld_idx(EX_ld_idx), .EX_st_idx(EX_st_idx),
    .iq_stall(iq_stall), .mispredict(mispredict), .flush_mask(flush_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ld_idx = rob[1:0], st_idx = ~rob[1:0] so the two index outputs are distinguishable.
  task automatic dp(input logic st, input logic [2:0] rob,
                    input logic r1, input logic [6:0] t1, input logic [31:0] d1,
                    input logic r2, input logic [6:0] t2, input logic [31:0] d2,
                    input logic [31:0] imm);
    dp_valid    = 1'b1;
    dp_is_st    = st;
    dp_rob_idx  = rob;
    dp_rd       = {4'd0, rob};
    dp_ld_idx   = rob[1:0];
    dp_st_idx   = ~rob[1:0];
    dp_imm      = imm;
    dp_rs1_rdy  = r1;
    dp_rs1_tag  = t1;
    dp_rs1_data = d1;
    dp_rs2_rdy  = r2;
    dp_rs2_tag  = t2;
    dp_rs2_data = d2;
  endtask

  task automatic nodp();
    dp_valid = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [6:0] t, input logic [31:0] d);
    wb_valid = v;
    wb_tag   = t;
    wb_data  = d;
  endtask

  initial begin
    rst = 1'b0; iq_stall = 1'b0; mispredict = 1'b0; flush_mask = '0;
    dp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nodp();
    wb(0, 0, 0);

    // Reset
    tick(); tick();
    chk("rst_dp_ready", dp_ready, 0);
    chk("rst_rr_valid", RR_valid, 0);
    chk("rst_ld_valid", ld_i_valid, 0);
    chk("rst_st_valid", st_i_valid, 0);
    chk("rst_rs1_data", lsu_i_rs1_data, 0);
    chk("rst_rob_idx", lsu_i_rob_idx, 0);
    rst = 1'b1;
    #1;
    chk("post_rst_dp_ready", dp_ready, 1);
    chk("post_rst_rr_valid", RR_valid, 0);

    // Single ready load
    dp(0, 3, 1, 0, 32'h100, 0, 0, 0, 4);
    tick();
    nodp();
    chk("ld_not_yet", RR_valid, 0);
    tick();
    chk("ld_valid", ld_i_valid, 1);
    chk("ld_st_valid", st_i_valid, 0);
    chk("ld_rs1", lsu_i_rs1_data, 32'h100);
    chk("ld_imm", lsu_i_imm, 4);
    chk("ld_rob", lsu_i_rob_idx, 3);
    chk("ld_ex_ld_idx", EX_ld_idx, 3);
    tick();
    chk("ld_idle_clear", RR_valid, 0);

    // Load passes a waiting store; store issues after wakeup
    dp(1, 1, 1, 0, 32'h200, 0, 9, 0, 8);
    tick();
    dp(0, 2, 1, 0, 32'h300, 1, 0, 0, 12);
    tick();
    nodp();
    tick();
    chk("pass_ld_valid", ld_i_valid, 1);
    chk("pass_ld_rob", lsu_i_rob_idx, 2);
    chk("pass_ld_rs1", lsu_i_rs1_data, 32'h300);
    wb(1, 9, 32'hDEAD);
    tick();
    wb(0, 0, 0);
    if (!BYP) tick();
    chk("wk_st_valid", st_i_valid, 1);
    chk("wk_st_ld_valid", ld_i_valid, 0);
    chk("wk_st_rob", lsu_i_rob_idx, 1);
    chk("wk_st_rs2", lsu_i_rs2_data, 32'hDEAD);
    chk("wk_st_rs1", lsu_i_rs1_data, 32'h200);
    chk("wk_st_ex_st_idx", EX_st_idx, 2);
    tick();
    chk("wk_idle", RR_valid, 0);

    // Younger ready store waits for older store
    dp(1, 1, 0, 5, 0, 1, 0, 32'h77, 0);
    tick();
    dp(1, 2, 1, 0, 32'hA, 1, 0, 32'hB, 0);
    tick();
    nodp();
    tick();
    chk("st_order_blk0", RR_valid, 0);
    tick();
    chk("st_order_blk1", RR_valid, 0);
    wb(1, 5, 32'h55);
    tick();
    wb(0, 0, 0);
    if (!BYP) tick();
    chk("st_order_first_vld", st_i_valid, 1);
    chk("st_order_first_rob", lsu_i_rob_idx, 1);
    chk("st_order_first_rs1", lsu_i_rs1_data, 32'h55);
    chk("st_order_first_rs2", lsu_i_rs2_data, 32'h77);
    tick();
    chk("st_order_second_vld", st_i_valid, 1);
    chk("st_order_second_rob", lsu_i_rob_idx, 2);
    tick();
    chk("st_order_idle", RR_valid, 0);

    // Full queue
    for (int k = 0; k < 4; k++) begin
      dp(0, 3'(4 + k), 0, 7'(10 + k), 0, 1, 0, 0, 0);
      tick();
    end
    chk("full_dp_ready", dp_ready, 0);
    dp(0, 0, 1, 0, 32'h999, 1, 0, 0, 0);
    tick();
    chk("full_ignored_ready", dp_ready, 0);
    chk("full_ignored_rr", RR_valid, 0);
    nodp();
    wb(1, 10, 32'h1010);
    tick();
    wb(0, 0, 0);
    if (!BYP) tick();
    chk("full_issue_vld", ld_i_valid, 1);
    chk("full_issue_rob", lsu_i_rob_idx, 4);
    chk("full_issue_rs1", lsu_i_rs1_data, 32'h1010);
    chk("full_freed_ready", dp_ready, 1);

    // Reset mid-operation discards queue and pending issue
    rst = 1'b0;
    tick();
    chk("mid_rst_rr", RR_valid, 0);
    chk("mid_rst_ld", ld_i_valid, 0);
    chk("mid_rst_dp_ready", dp_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_release_ready", dp_ready, 1);
    wb(1, 11, 32'h11);
    tick();
    wb(1, 12, 32'h12);
    tick();
    chk("mid_rst_discard0", RR_valid, 0);
    wb(0, 0, 0);
    tick(); tick();
    chk("mid_rst_discard1", RR_valid, 0);

    // Mispredict flush of rob 3 (issue reg) and rob 4 (queue)
    dp(0, 3, 1, 0, 32'h33, 1, 0, 0, 0);
    tick();
    dp(0, 2, 0, 20, 0, 1, 0, 0, 0);
    tick();
    chk("fl_issue_rob3", lsu_i_rob_idx, 3);
    chk("fl_issue_vld", ld_i_valid, 1);
    dp(0, 4, 0, 21, 0, 1, 0, 0, 0);
    iq_stall = 1'b1;
    tick();
    chk("fl_held_rob3", lsu_i_rob_idx, 3);
    mispredict = 1'b1;
    flush_mask = 8'b0001_1000;
    dp(0, 6, 1, 0, 32'h66, 1, 0, 0, 0);
    tick();
    chk("fl_issue_cleared", RR_valid, 0);
    chk("fl_dp_ready", dp_ready, 1);
    mispredict = 1'b0;
    flush_mask = '0;
    iq_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dp(0, 3'(5 + k), 0, 7'(30 + k), 0, 1, 0, 0, 0);
      tick();
    end
    nodp();
    chk("fl_count_one_full", dp_ready, 0);
    chk("fl_no_stray_issue", RR_valid, 0);
    wb(1, 20, 32'h22);
    tick();
    wb(1, 21, 32'h21);
    if (!BYP) tick();
    chk("fl_survivor_vld", ld_i_valid, 1);
    chk("fl_survivor_rob", lsu_i_rob_idx, 2);
    chk("fl_survivor_rs1", lsu_i_rs1_data, 32'h22);
    tick();
    wb(0, 0, 0);
    tick();
    chk("fl_rob4_gone", RR_valid, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Stall holds the issue register
    dp(0, 1, 1, 0, 32'h11, 1, 0, 0, 0);
    tick();
    dp(0, 2, 1, 0, 32'h22, 1, 0, 0, 0);
    tick();
    nodp();
    iq_stall = 1'b1;
    chk("stall_first_rob", lsu_i_rob_idx, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_vld", ld_i_valid, 1);
      chk("stall_hold_rob", lsu_i_rob_idx, 1);
      chk("stall_hold_rs1", lsu_i_rs1_data, 32'h11);
    end
    iq_stall = 1'b0;
    tick();
    chk("stall_release_vld", ld_i_valid, 1);
    chk("stall_release_rob", lsu_i_rob_idx, 2);
    chk("stall_release_rs1", lsu_i_rs1_data, 32'h22);
    tick();
    chk("stall_idle", RR_valid, 0);

    // Tag 0 never wakes
    dp(0, 5, 0, 0, 0, 1, 0, 0, 0);
    tick();
    nodp();
    wb(1, 0, 32'hBAD);
    tick(); tick();
    chk("tag0_no_wake", RR_valid, 0);
    wb(0, 0, 0);
    tick();
    chk("tag0_still_idle", RR_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
